// File: rtl/vga_timing_driver.sv
// rtl/vga_timing_driver.sv - 640x480@60 VGA timing generator and RRRGGGBB colour expander for the board DAC
module vga_timing_driver #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] color_in,
    output logic [9:0] current_pixel_x,
    output logic [9:0] current_pixel_y,
    output logic       pixel_tick,
    output logic       frame_start,
    output logic       vga_clk,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_nxt;
    logic             x_wrap;
    logic             y_wrap;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             active0;
    logic             hs0;
    logic             vs0;
    logic [2:0]       r3;
    logic [2:0]       g3;
    logic [1:0]       b2;

    assign r3 = color_in[7:5];
    assign g3 = color_in[4:2];
    assign b2 = color_in[1:0];

    assign vga_sync_n = 1'b0;

    // Next-state values; everything registered below is derived from these so
    // the stage-0 flags always describe the coordinates held in x/y.
    always_comb begin
        div_nxt  = (div == DIV_LAST) ? '0 : div + 1'b1;
        tick_nxt = (div_nxt == DIV_LAST);
        x_wrap   = (current_pixel_x == X_LAST);
        y_wrap   = (current_pixel_y == Y_LAST);
        x_nxt    = current_pixel_x;
        y_nxt    = current_pixel_y;
        if (pixel_tick) begin
            x_nxt = x_wrap ? 10'd0 : current_pixel_x + 10'd1;
            if (x_wrap) begin
                y_nxt = y_wrap ? 10'd0 : current_pixel_y + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div             <= '0;
            pixel_tick      <= 1'b0;
            frame_start     <= 1'b0;
            vga_clk         <= 1'b0;
            current_pixel_x <= 10'd0;
            current_pixel_y <= 10'd0;
            active0         <= 1'b1;
            hs0             <= 1'b1;
            vs0             <= 1'b1;
        end else begin
            div             <= div_nxt;
            pixel_tick      <= tick_nxt;
            frame_start     <= tick_nxt && (x_nxt == X_LAST) && (y_nxt == Y_LAST);
            // High for the second half of the pixel period: rising edge mid-pixel.
            vga_clk         <= (div_nxt >= DIV_HALF);
            current_pixel_x <= x_nxt;
            current_pixel_y <= y_nxt;
            active0         <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
            hs0             <= !((x_nxt >= HS_START) && (x_nxt <= HS_END));
            vs0             <= !((y_nxt >= VS_START) && (y_nxt <= VS_END));
        end
    end

    // Output stage: colour and flags of the same pixel land together, one pixel late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pixel_tick) begin
            vga_r       <= active0 ? {r3, r3, r3[2:1]} : 8'd0;
            vga_g       <= active0 ? {g3, g3, g3[2:1]} : 8'd0;
            vga_b       <= active0 ? {b2, b2, b2, b2}  : 8'd0;
            vga_hs      <= hs0;
            vga_vs      <= vs0;
            vga_blank_n <= active0;
        end
    end

endmodule

// File: tb/tb_vga_timing_driver.sv
// tb/tb_vga_timing_driver.sv - randomized bench for vga_timing_driver against a pixel-index reference model
module tb_vga_timing_driver;

    localparam int CLK_DIV = 2;
    localparam int HA = 40, HF = 4, HS = 8, HB = 6;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] color_in;
    logic [9:0] current_pixel_x, current_pixel_y;
    logic       pixel_tick, frame_start, vga_clk;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    vga_timing_driver #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .color_in(color_in),
        .current_pixel_x(current_pixel_x), .current_pixel_y(current_pixel_y),
        .pixel_tick(pixel_tick), .frame_start(frame_start), .vga_clk(vga_clk),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int         j;
    int         k;
    int         fs_last_j;
    int         blank_cnt;
    int         hs_run;
    int         vs_run;
    logic [7:0] exp_r, exp_g, exp_b;
    logic       exp_hs, exp_vs, exp_blank;
    logic [7:0] spec_colors [3];

    function automatic int scale3(input int v);
        return (v * 255 + 3) / 7;
    endfunction

    task automatic model_reset();
        j = 0; k = 0; fs_last_j = -1; blank_cnt = 0; hs_run = 0; vs_run = 0;
        exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
        exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (ncyc) @(negedge clk);
        check("rst_x", current_pixel_x, 0);
        check("rst_y", current_pixel_y, 0);
        check("rst_tick", pixel_tick, 0);
        check("rst_fs", frame_start, 0);
        check("rst_vga_clk", vga_clk, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_blank", vga_blank_n, 0);
        check("sync_n", vga_sync_n, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle();
        int  px, py;
        bit  tick_exp, act;
        logic [7:0] c;
        @(negedge clk);
        tick_exp = ((j % CLK_DIV) == CLK_DIV - 2);
        check("pixel_tick", pixel_tick, tick_exp);
        check("vga_clk", vga_clk, (((j + 1) % CLK_DIV) >= CLK_DIV / 2));
        check("vga_r", vga_r, exp_r);
        check("vga_g", vga_g, exp_g);
        check("vga_b", vga_b, exp_b);
        check("vga_hs", vga_hs, exp_hs);
        check("vga_vs", vga_vs, exp_vs);
        check("blank_n", vga_blank_n, exp_blank);
        if (tick_exp) begin
            px = k % HT;
            py = (k / HT) % VT;
            check("x", current_pixel_x, px);
            check("y", current_pixel_y, py);
            check("frame_start", frame_start, ((k % FR) == FR - 1));
            if (vga_blank_n === 1'b1) blank_cnt++;
            if (vga_hs === 1'b0) hs_run++;
            else if (hs_run != 0) begin
                check("hs_width", hs_run, HS);
                hs_run = 0;
            end
            if (vga_vs === 1'b0) vs_run++;
            else if (vs_run != 0) begin
                check("vs_width", vs_run, VS * HT);
                vs_run = 0;
            end
            if ((k % FR) == FR - 1) begin
                check("blank_count", blank_cnt, HA * VA);
                blank_cnt = 0;
                if (fs_last_j >= 0) check("frame_period", j - fs_last_j, FR * CLK_DIV);
                fs_last_j = j;
            end
            case (py % 4)
                0: c = 8'($urandom);
                1: c = 8'(px);
                2: c = 8'hFF;
                default: c = spec_colors[px % 3];
            endcase
            color_in = c;
            act       = (px < HA) && (py < VA);
            exp_blank = act;
            exp_hs    = !((px >= HA + HF) && (px < HA + HF + HS));
            exp_vs    = !((py >= VA + VF) && (py < VA + VF + VS));
            exp_r     = act ? 8'(scale3(int'(c[7:5]))) : 8'd0;
            exp_g     = act ? 8'(scale3(int'(c[4:2]))) : 8'd0;
            exp_b     = act ? 8'(int'(c[1:0]) * 85) : 8'd0;
            k++;
        end else begin
            check("frame_start_idle", frame_start, 0);
            color_in = 8'($urandom);
        end
        j++;
    endtask

    initial begin
        spec_colors[0] = 8'b11100000;
        spec_colors[1] = 8'b01111011;
        spec_colors[2] = 8'b11111100;
        rst_n    = 1'b0;
        color_in = 8'd0;
        model_reset();
        do_reset(3);
        repeat (2 * FR * CLK_DIV + 40) cycle();
        while ((k % FR) != 3 * HT + 11) cycle();
        do_reset(1);
        repeat (FR * CLK_DIV + 100) cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
